// File: rtl/aux_memory_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aux_memory_loader_if                                            |
// | Purpose  : Read-request bus between aux_memory_loader and CPU memory.      |
// |            Each request holds sel/addr stable until mem_ack_in is high;    |
// |            mem_data_in is valid in the ack cycle.                          |
// | Ports    : mem_req_out  - read request (loader -> memory)                  |
// |            mem_sel_out  - 0 = instruction memory, 1 = data memory          |
// |            mem_addr_out - word address                                     |
// |            mem_ack_in   - read acknowledge (memory -> loader)              |
// |            mem_data_in  - read data, valid with mem_ack_in                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface aux_memory_loader_if #(
  parameter int DATA_WIDTH           = 16,
  parameter int MEMORY_ADDRESS_WIDTH = 11
);
  logic                            mem_req_out;
  logic                            mem_sel_out;
  logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_out;
  logic                            mem_ack_in;
  logic [DATA_WIDTH-1:0]           mem_data_in;

  modport master (
    output mem_req_out, mem_sel_out, mem_addr_out,
    input  mem_ack_in,  mem_data_in
  );

  modport slave (
    input  mem_req_out, mem_sel_out, mem_addr_out,
    output mem_ack_in,  mem_data_in
  );
endinterface
`default_nettype wire

// File: rtl/aux_memory_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aux_memory_loader                                               |
// | Purpose  : On each frame start, snapshots CPU registers plus two windows   |
// |            of CPU memory (around pc and daddr) into a shadow bank, then    |
// |            swaps it with the display bank so the display always sees a     |
// |            consistent snapshot.                                            |
// | Ports    : clk_in, reset_in     - clock, synchronous active-high reset     |
// |            frame_start_in       - one-cycle pulse, starts a snapshot       |
// |            cpu_*_in             - CPU register values to capture           |
// |            mem                  - memory read bus (master side)            |
// |            aux_raddress_in      - display read address                     |
// |            aux_data_out         - display read data, 1-cycle latency       |
// |            busy_out             - high while a snapshot is in progress     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module aux_memory_loader #(
  parameter int DATA_WIDTH           = 16,
  parameter int MEMORY_ADDRESS_WIDTH = 11,
  parameter int AUX_ADDRESS_WIDTH    = 5,
  parameter int CPU_ELEMENTS         = 10,
  parameter int MEMORY_ELEMENTS      = 10
) (
  input  wire logic                         clk_in,
  input  wire logic                         reset_in,
  input  wire logic                         frame_start_in,
  input  wire logic [DATA_WIDTH-1:0]        cpu_pc_in,
  input  wire logic [DATA_WIDTH-1:0]        cpu_instr_in,
  input  wire logic [DATA_WIDTH-1:0]        cpu_daddr_in,
  input  wire logic [DATA_WIDTH-1:0]        cpu_data_in,
  input  wire logic [DATA_WIDTH-1:0]        cpu_ir_in,
  input  wire logic [DATA_WIDTH-1:0]        cpu_acc_in,
  input  wire logic [DATA_WIDTH-1:0]        cpu_alu_a_in,
  input  wire logic [DATA_WIDTH-1:0]        cpu_alu_b_in,
  input  wire logic                         cpu_clock_level_in,
  input  wire logic [1:0]                   cpu_status_in,
  aux_memory_loader_if.master               mem,
  input  wire logic [AUX_ADDRESS_WIDTH-1:0] aux_raddress_in,
  output logic      [DATA_WIDTH-1:0]        aux_data_out,
  output logic                              busy_out
);

  localparam int AUX_ENTRIES = 2 ** AUX_ADDRESS_WIDTH;
  localparam int USED        = CPU_ELEMENTS + 2 * MEMORY_ELEMENTS;
  localparam int KW          = (MEMORY_ELEMENTS > 1) ? $clog2(MEMORY_ELEMENTS) : 1;
  // Base arithmetic is done one bit wider than either operand so that the
  // full CPU value can be compared against the top-of-memory limit.
  localparam int CW          = ((DATA_WIDTH > MEMORY_ADDRESS_WIDTH) ? DATA_WIDTH
                                                                   : MEMORY_ADDRESS_WIDTH) + 1;
  localparam logic [CW-1:0]                C_F      = {{(CW-MEMORY_ADDRESS_WIDTH){1'b0}},
                                                       {MEMORY_ADDRESS_WIDTH{1'b1}}};
  localparam logic [AUX_ADDRESS_WIDTH:0]   C_USED_L = USED[AUX_ADDRESS_WIDTH:0];
  localparam logic [KW-1:0]                C_KLAST  = KW'(MEMORY_ELEMENTS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_FETCH_I = 3'd2,
    S_FETCH_D = 3'd3,
    S_COMMIT  = 3'd4
  } state_t;

  // Window base: centred on v (v-4), clamped so the window stays inside memory.
  function automatic logic [MEMORY_ADDRESS_WIDTH-1:0] f_base(input logic [DATA_WIDTH-1:0] v);
    logic [CW-1:0] w;
    w = CW'(v);
    if (w < CW'(5))
      return '0;
    else if (w > C_F - CW'(5))
      return MEMORY_ADDRESS_WIDTH'(C_F - CW'(MEMORY_ELEMENTS - 1));
    else
      return MEMORY_ADDRESS_WIDTH'(w - CW'(4));
  endfunction

  state_t                          state_q, state_d;
  logic [KW-1:0]                   k_q, k_d;
  logic [MEMORY_ADDRESS_WIDTH-1:0] ibase_q, ibase_d;
  logic [MEMORY_ADDRESS_WIDTH-1:0] dbase_q, dbase_d;
  logic                            req_q, req_d;
  logic                            sel_q, sel_d;
  logic [MEMORY_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                            bank_sel_q, bank_sel_d;
  logic [DATA_WIDTH-1:0]           aux_data_q;
  logic [DATA_WIDTH-1:0]           bank_q [2][AUX_ENTRIES];

  logic                            fetch_wr;
  logic [AUX_ADDRESS_WIDTH-1:0]    wr_idx;
  logic                            shadow_sel;

  assign shadow_sel = ~bank_sel_q;
  assign wr_idx     = AUX_ADDRESS_WIDTH'(CPU_ELEMENTS)
                    + ((state_q == S_FETCH_D) ? AUX_ADDRESS_WIDTH'(MEMORY_ELEMENTS)
                                              : {AUX_ADDRESS_WIDTH{1'b0}})
                    + AUX_ADDRESS_WIDTH'(k_q);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    ibase_d    = ibase_q;
    dbase_d    = dbase_q;
    req_d      = req_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    bank_sel_d = bank_sel_q;
    fetch_wr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start_in) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        ibase_d = f_base(cpu_pc_in);
        dbase_d = f_base(cpu_daddr_in);
        k_d     = '0;
        state_d = S_FETCH_I;
      end
      S_FETCH_I, S_FETCH_D: begin
        if (!req_q) begin
          // Request is raised from a low cycle, which also provides the
          // mandatory one-cycle gap after every acknowledge.
          req_d  = 1'b1;
          sel_d  = (state_q == S_FETCH_D);
          addr_d = ((state_q == S_FETCH_D) ? dbase_q : ibase_q)
                 + MEMORY_ADDRESS_WIDTH'(k_q);
        end else if (mem.mem_ack_in) begin
          fetch_wr = 1'b1;
          req_d    = 1'b0;
          if (k_q == C_KLAST) begin
            k_d     = '0;
            state_d = (state_q == S_FETCH_I) ? S_FETCH_D : S_COMMIT;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      S_COMMIT: begin
        bank_sel_d = ~bank_sel_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      ibase_q    <= '0;
      dbase_q    <= '0;
      req_q      <= 1'b0;
      sel_q      <= 1'b0;
      addr_q     <= '0;
      bank_sel_q <= 1'b0;
      aux_data_q <= '0;
      for (int b = 0; b < 2; b++)
        for (int e = 0; e < AUX_ENTRIES; e++)
          bank_q[b][e] <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      ibase_q    <= ibase_d;
      dbase_q    <= dbase_d;
      req_q      <= req_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      bank_sel_q <= bank_sel_d;
      // Uses the pre-swap bank select, so a read in the COMMIT cycle still
      // returns the old snapshot.
      aux_data_q <= ({1'b0, aux_raddress_in} >= C_USED_L) ? '0
                                                          : bank_q[bank_sel_q][aux_raddress_in];
      if (state_q == S_CAPTURE) begin
        bank_q[shadow_sel][0] <= cpu_pc_in;
        bank_q[shadow_sel][1] <= cpu_instr_in;
        bank_q[shadow_sel][2] <= cpu_daddr_in;
        bank_q[shadow_sel][3] <= cpu_data_in;
        bank_q[shadow_sel][4] <= cpu_ir_in;
        bank_q[shadow_sel][5] <= cpu_acc_in;
        bank_q[shadow_sel][6] <= cpu_alu_a_in;
        bank_q[shadow_sel][7] <= cpu_alu_b_in;
        bank_q[shadow_sel][8] <= DATA_WIDTH'(cpu_clock_level_in);
        bank_q[shadow_sel][9] <= DATA_WIDTH'(cpu_status_in);
      end
      if (fetch_wr) bank_q[shadow_sel][wr_idx] <= mem.mem_data_in;
    end
  end

  assign mem.mem_req_out  = req_q;
  assign mem.mem_sel_out  = sel_q;
  assign mem.mem_addr_out = addr_q;
  assign aux_data_out     = aux_data_q;
  assign busy_out         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/aux_memory_loader.md
AUX_MEMORY_LOADER -- requirements
Module: aux_memory_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of CPU words and aux entries.
REQ-002 SHALL have parameter MEMORY_ADDRESS_WIDTH, default 11, width of CPU memory addresses.
REQ-003 SHALL have parameter AUX_ADDRESS_WIDTH, default 5, giving 32 aux entries.
REQ-004 SHALL have parameter CPU_ELEMENTS, default 10, count of CPU register entries.
REQ-005 SHALL have parameter MEMORY_ELEMENTS, default 10, count of words per memory window.
REQ-006 SHALL have port clk_in, in, 1, the single clock.
REQ-007 SHALL have port reset_in, in, 1, synchronous active-high reset.
REQ-008 SHALL have port frame_start_in, in, 1, one-cycle pulse at start of vertical blank.
REQ-009 SHALL have ports cpu_pc_in, cpu_instr_in, cpu_daddr_in, cpu_data_in, cpu_ir_in, cpu_acc_in, cpu_alu_a_in and cpu_alu_b_in, in, DATA_WIDTH, the CPU values.
REQ-010 SHALL have port cpu_clock_level_in, in, 1, the CPU clock level.
REQ-011 SHALL have port cpu_status_in, in, 2, with bit1 = Z and bit0 = N.
REQ-012 SHALL have port mem_req_out, out, 1, CPU memory read request.
REQ-013 SHALL have port mem_sel_out, out, 1, memory select: 0 = instruction, 1 = data.
REQ-014 SHALL have port mem_addr_out, out, MEMORY_ADDRESS_WIDTH, the read address.
REQ-015 SHALL have port mem_ack_in, in, 1, read acknowledge, with mem_data_in valid in the same cycle.
REQ-016 SHALL have port mem_data_in, in, DATA_WIDTH, read data.
REQ-017 SHALL have port aux_raddress_in, in, AUX_ADDRESS_WIDTH, display read address.
REQ-018 SHALL have port aux_data_out, out, DATA_WIDTH, display read data.
REQ-019 SHALL have port busy_out, out, 1, high while a snapshot is in progress.

Function
REQ-020 SHALL hold two banks of 32 x DATA_WIDTH entries, one active (display) bank and one shadow (write) bank.
REQ-021 SHALL register aux_data_out <= active[aux_raddress_in] every cycle (latency 1); addresses 30 and 31 SHALL read 0.
REQ-022 SHALL implement FSM states IDLE, CAPTURE, FETCH_I, FETCH_D and COMMIT; transition IDLE->CAPTURE on frame_start_in; frame_start_in in any other state SHALL be ignored and not queued.
REQ-023 In CAPTURE (1 cycle), the block SHALL write shadow entries 0..7 from pc, instr, daddr, data, ir, acc, alu_a and alu_b, write entry 8 = zero-extended clock_level, write entry 9 = zero-extended {Z,N}, and latch ibase and dbase.
REQ-024 SHALL compute the base from the full DATA_WIDTH value v (pc for ibase, daddr for dbase), with F = 2^MEMORY_ADDRESS_WIDTH-1: v<5 -> 0; v>F-5 -> F-9; otherwise v-4.
REQ-025 In FETCH_I, for k=0..9, the block SHALL present mem_sel_out=0 and mem_addr_out=ibase+k with mem_req_out=1, holding both stable until mem_ack_in; on ack it SHALL write mem_data_in to shadow entry 10+k.
REQ-026 After each ack, mem_req_out SHALL be 0 for exactly one cycle before the next request.
REQ-027 After k=9 is acked in FETCH_I, the block SHALL go to FETCH_D, which SHALL behave identically with mem_sel_out=1, base dbase and entries 20+k.
REQ-028 SHALL ignore mem_ack_in while mem_req_out=0.
REQ-029 COMMIT (1 cycle) SHALL swap the active and shadow banks and return to IDLE; a read registered in the COMMIT cycle SHALL return old-bank data, and the next read SHALL return new-bank data.
REQ-030 busy_out SHALL be 1 in CAPTURE, FETCH_I, FETCH_D and COMMIT, and 0 in IDLE.
REQ-031 The active bank SHALL never be written; displayed data changes only at COMMIT.
REQ-032 Address arithmetic SHALL use MEMORY_ADDRESS_WIDTH bits; ibase+k and dbase+k SHALL never exceed F.

Reset
REQ-033 When reset_in is high at a clock edge: FSM->IDLE, both banks cleared to 0, active bank = bank 0, mem_req_out=0, mem_sel_out=0, mem_addr_out=0, aux_data_out=0, busy_out=0.
REQ-034 Reset during FETCH_I or FETCH_D SHALL abort the snapshot without a swap; a late ack after reset SHALL be ignored.

Verification
REQ-035 Reset, then read addresses 0..31: all aux_data_out=0, busy_out=0, mem_req_out=0.
REQ-036 pc=0x0003, daddr=0x0100, ack after 2-cycle delay: instruction reads of 0..9 with sel=0, data reads of 0x0FC..0x105 with sel=1; after COMMIT, entry 0=0x0003, entries 10..19 and 20..29 equal the returned words.
REQ-037 pc=0x07FD (>2042) -> instruction reads 0x7F6..0x7FF; pc=0xFFFF -> same addresses; pc=5 -> 1..10.
REQ-038 With status=2'b10 and clock_level=1 -> entry 9=0x0002 and entry 8=0x0001; repeated reads of entry 9 during the fetch still return the previous snapshot until COMMIT.
REQ-039 A frame_start_in pulse during FETCH_D is ignored (exactly 20 requests in total); reset asserted at the 5th instruction request -> idle next cycle, no swap, active bank unchanged.
